// File: rtl/urna_pkg.sv
// Shared types and constants for the vote tally path.
package urna_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_UPDATE,
    ST_SCAN,
    ST_CLOSED
  } estado_t;

  typedef enum logic [2:0] {
    CL_CAND0,
    CL_CAND1,
    CL_CAND2,
    CL_CAND3,
    CL_NULO
  } classe_t;

  localparam int          NUM_CAND     = 4;
  localparam logic [7:0]  CAND0_DEF    = 8'h10;
  localparam logic [7:0]  CAND1_DEF    = 8'h13;
  localparam logic [7:0]  CAND2_DEF    = 8'h17;
  localparam logic [7:0]  CAND3_DEF    = 8'h51;
  localparam logic [7:0]  BCD_MAX      = 8'h99;
  localparam logic [3:0]  SEM_VENC     = 4'hF;

  // One BCD step on a two-digit value; callers never pass 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_contador2.sv
// Two-digit BCD counter with synchronous clear and increment enable.
module bcd_contador2
  import urna_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q, cnt_d;

  // Clear wins over increment so an abandoned vote never lands.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 8'h00;
    else if (inc_i) cnt_d = bcd_inc(cnt_q);
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= 8'h00;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/apuracao_votos.sv
// Vote tally: decode one vote, bump BCD counters, rescan for the winner.
module apuracao_votos
  import urna_pkg::*;
#(
  parameter logic [7:0] CAND0_CODE = CAND0_DEF,
  parameter logic [7:0] CAND1_CODE = CAND1_DEF,
  parameter logic [7:0] CAND2_CODE = CAND2_DEF,
  parameter logic [7:0] CAND3_CODE = CAND3_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vote_valid,
  output logic        vote_ready,
  input  logic [3:0]  dig1,
  input  logic [3:0]  dig2,
  input  logic        finalizar,
  input  logic        clear,
  output logic [31:0] cand_bcd,
  output logic [7:0]  nulo_bcd,
  output logic [7:0]  total_bcd,
  output logic [3:0]  venc_d1,
  output logic [3:0]  venc_d2,
  output logic        venc_valid,
  output logic        empate,
  output logic        fechado,
  output logic        saturado
);

  localparam logic [NUM_CAND-1:0][7:0] CODES = {CAND3_CODE, CAND2_CODE, CAND1_CODE, CAND0_CODE};

  estado_t state_q, state_d;
  logic    vote_ready_q, vote_ready_d;
  logic    fechado_q, fechado_d;

  logic [7:0]  dig_q;
  classe_t     class_q, class_d;
  logic [1:0]  scan_idx_q;
  logic [7:0]  max_q, max_d;
  logic [1:0]  midx_q, midx_d;
  logic        tie_q, tie_d;
  logic [3:0]  venc_d1_q, venc_d1_d, venc_d2_q, venc_d2_d;
  logic        venc_valid_q, venc_valid_d, empate_q, empate_d;
  logic        saturado_q, saturado_d;

  logic [NUM_CAND-1:0][7:0] cand_cnt;
  logic [NUM_CAND-1:0]      inc_cand;
  logic [7:0]               nulo_cnt, total_cnt;
  logic                     inc_nulo, sat, upd, scan_last;
  logic [7:0]               cur;

  assign sat       = (total_cnt == BCD_MAX);
  assign upd       = (state_q == ST_UPDATE) && !sat;
  assign scan_last = (state_q == ST_SCAN) && (scan_idx_q == 2'd3);

  // State register; ready/closed flags registered from next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      vote_ready_q <= 1'b1;
      fechado_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vote_ready_q <= vote_ready_d;
      fechado_q    <= fechado_d;
    end
  end

  // Next state; clear overrides everything, a vote beats finalizar.
  always_comb begin
    state_d = state_q;
    if (clear) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:   if (vote_valid) state_d = ST_DECODE;
                   else if (finalizar) state_d = ST_CLOSED;
        ST_DECODE: state_d = ST_UPDATE;
        ST_UPDATE: state_d = ST_SCAN;
        ST_SCAN:   if (scan_idx_q == 2'd3) state_d = ST_IDLE;
        ST_CLOSED: state_d = ST_CLOSED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output flags derived from the state being entered.
  always_comb begin
    vote_ready_d = (state_d == ST_IDLE);
    fechado_d    = (state_d == ST_CLOSED);
  end

  // Classify latched digits; anything not a known code is null.
  always_comb begin
    class_d = CL_NULO;
    if (dig_q[7:4] <= 4'd9 && dig_q[3:0] <= 4'd9) begin
      if      (dig_q == CODES[0]) class_d = CL_CAND0;
      else if (dig_q == CODES[1]) class_d = CL_CAND1;
      else if (dig_q == CODES[2]) class_d = CL_CAND2;
      else if (dig_q == CODES[3]) class_d = CL_CAND3;
    end
  end

  // Route the single increment; saturation gates all of them via upd.
  always_comb begin
    inc_cand = '0;
    inc_nulo = 1'b0;
    if (upd) begin
      case (class_q)
        CL_CAND0: inc_cand[0] = 1'b1;
        CL_CAND1: inc_cand[1] = 1'b1;
        CL_CAND2: inc_cand[2] = 1'b1;
        CL_CAND3: inc_cand[3] = 1'b1;
        default:  inc_nulo    = 1'b1;
      endcase
    end
  end

  // Running max over one candidate per cycle; BCD compares as binary.
  always_comb begin
    cur    = cand_cnt[scan_idx_q];
    max_d  = max_q;
    midx_d = midx_q;
    tie_d  = tie_q;
    if (scan_idx_q == 2'd0) begin
      max_d  = cur;
      midx_d = 2'd0;
      tie_d  = 1'b0;
    end else if (cur > max_q) begin
      max_d  = cur;
      midx_d = scan_idx_q;
      tie_d  = 1'b0;
    end else if (cur == max_q && cur != 8'h00) begin
      tie_d  = 1'b1;
    end
  end

  // Winner / saturation next values; held outside the last scan cycle.
  always_comb begin
    venc_d1_d    = venc_d1_q;
    venc_d2_d    = venc_d2_q;
    venc_valid_d = venc_valid_q;
    empate_d     = empate_q;
    saturado_d   = saturado_q;
    if (clear) begin
      venc_d1_d    = SEM_VENC;
      venc_d2_d    = SEM_VENC;
      venc_valid_d = 1'b0;
      empate_d     = 1'b0;
      saturado_d   = 1'b0;
    end else begin
      if (state_q == ST_UPDATE && sat) saturado_d = 1'b1;
      if (scan_last) begin
        venc_valid_d = (max_d != 8'h00) && !tie_d;
        empate_d     = (max_d != 8'h00) && tie_d;
        venc_d1_d    = venc_valid_d ? CODES[midx_d][7:4] : SEM_VENC;
        venc_d2_d    = venc_valid_d ? CODES[midx_d][3:0] : SEM_VENC;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dig_q        <= 8'h00;
      class_q      <= CL_NULO;
      scan_idx_q   <= 2'd0;
      max_q        <= 8'h00;
      midx_q       <= 2'd0;
      tie_q        <= 1'b0;
      venc_d1_q    <= SEM_VENC;
      venc_d2_q    <= SEM_VENC;
      venc_valid_q <= 1'b0;
      empate_q     <= 1'b0;
      saturado_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && vote_valid) dig_q <= {dig1, dig2};
      class_q      <= class_d;
      scan_idx_q   <= (state_q == ST_SCAN) ? scan_idx_q + 2'd1 : 2'd0;
      max_q        <= max_d;
      midx_q       <= midx_d;
      tie_q        <= tie_d;
      venc_d1_q    <= venc_d1_d;
      venc_d2_q    <= venc_d2_d;
      venc_valid_q <= venc_valid_d;
      empate_q     <= empate_d;
      saturado_q   <= saturado_d;
    end
  end

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
    bcd_contador2 u_cnt (
      .clock (clock),
      .reset (reset),
      .clr_i (clear),
      .inc_i (inc_cand[k]),
      .cnt_o (cand_cnt[k])
    );
  end

  bcd_contador2 u_nulo (
    .clock (clock),
    .reset (reset),
    .clr_i (clear),
    .inc_i (inc_nulo),
    .cnt_o (nulo_cnt)
  );

  bcd_contador2 u_total (
    .clock (clock),
    .reset (reset),
    .clr_i (clear),
    .inc_i (upd),
    .cnt_o (total_cnt)
  );

  assign vote_ready = vote_ready_q;
  assign fechado    = fechado_q;
  assign cand_bcd   = cand_cnt;
  assign nulo_bcd   = nulo_cnt;
  assign total_bcd  = total_cnt;
  assign venc_d1    = venc_d1_q;
  assign venc_d2    = venc_d2_q;
  assign venc_valid = venc_valid_q;
  assign empate     = empate_q;
  assign saturado   = saturado_q;

endmodule
